// File: rtl/t10_word_buffer.sv
// Builds a guess word from UART receive bytes, with backspace, enter-to-commit and case folding.
// The committed word is held for the game FSM under a valid/ack handshake.
module t10_word_buffer #(
    parameter int          WORD_LEN   = 5,
    parameter bit          CASE_FOLD  = 1'b1,
    parameter logic [7:0]  BS_CODE    = 8'h08,
    parameter logic [7:0]  ENTER_CODE = 8'h0D,
    localparam int         CW         = $clog2(WORD_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    nRst,
    input  logic [7:0]              rx_byte_i,
    input  logic                    rx_ready_i,
    input  logic                    game_rdy_i,
    input  logic                    word_ack_i,
    output logic [8*WORD_LEN-1:0]   word_out_o,
    output logic                    word_valid_o,
    output logic [CW-1:0]           char_count_o,
    output logic [7:0]              echo_char_o,
    output logic                    echo_stb_o,
    output logic                    rx_err_o
);

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

    state_t          state_q, state_d;
    logic [7:0]      slot_q [WORD_LEN];
    logic [7:0]      slot_d [WORD_LEN];
    logic [CW-1:0]   count_q, count_d;
    logic [7:0]      echo_char_q, echo_char_d;
    logic            echo_stb_q, echo_stb_d;
    logic            rx_err_q, rx_err_d;
    logic            word_valid_q, word_valid_d;

    logic            is_lower, is_upper, is_letter, is_bs;
    logic [7:0]      lower_byte;

    always_comb begin
        is_lower   = (rx_byte_i >= 8'h61) && (rx_byte_i <= 8'h7A);
        is_upper   = (rx_byte_i >= 8'h41) && (rx_byte_i <= 8'h5A);
        is_letter  = is_lower || (CASE_FOLD && is_upper);
        is_bs      = (rx_byte_i == BS_CODE) || (rx_byte_i == 8'h7F);
        lower_byte = is_upper ? (rx_byte_i | 8'h20) : rx_byte_i;
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        count_d     = count_q;
        echo_char_d = echo_char_q;
        echo_stb_d  = 1'b0;
        rx_err_d    = 1'b0;
        // Losing game_rdy always flushes, regardless of what the byte stream is doing.
        if (!game_rdy_i) begin
            state_d = IDLE;
            count_d = '0;
            for (int i = 0; i < WORD_LEN; i++) slot_d[i] = 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = COLLECT;
                    count_d = '0;
                    for (int i = 0; i < WORD_LEN; i++) slot_d[i] = 8'h00;
                end
                COLLECT: begin
                    if (rx_ready_i) begin
                        if (is_letter) begin
                            if (count_q < CW'(WORD_LEN)) begin
                                for (int i = 0; i < WORD_LEN; i++)
                                    if (CW'(i) == count_q) slot_d[i] = lower_byte;
                                count_d     = count_q + CW'(1);
                                echo_char_d = lower_byte;
                                echo_stb_d  = 1'b1;
                            end else begin
                                rx_err_d = 1'b1;
                            end
                        end else if (is_bs) begin
                            if (count_q != '0) begin
                                for (int i = 0; i < WORD_LEN; i++)
                                    if (CW'(i + 1) == count_q) slot_d[i] = 8'h00;
                                count_d = count_q - CW'(1);
                            end else begin
                                rx_err_d = 1'b1;
                            end
                        end else if ((rx_byte_i == ENTER_CODE) && (count_q == CW'(WORD_LEN))) begin
                            state_d = COMMIT;
                        end else begin
                            rx_err_d = 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    rx_err_d = rx_ready_i;
                    if (word_ack_i) begin
                        state_d = COLLECT;
                        count_d = '0;
                        for (int i = 0; i < WORD_LEN; i++) slot_d[i] = 8'h00;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        word_valid_d = (state_d == COMMIT);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            echo_char_q  <= 8'h00;
            echo_stb_q   <= 1'b0;
            rx_err_q     <= 1'b0;
            word_valid_q <= 1'b0;
            for (int i = 0; i < WORD_LEN; i++) slot_q[i] <= 8'h00;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            echo_char_q  <= echo_char_d;
            echo_stb_q   <= echo_stb_d;
            rx_err_q     <= rx_err_d;
            word_valid_q <= word_valid_d;
            for (int i = 0; i < WORD_LEN; i++) slot_q[i] <= slot_d[i];
        end
    end

    // Slot 0 (first letter typed) lands in the most significant byte.
    always_comb begin
        word_out_o = '0;
        if (word_valid_q)
            for (int i = 0; i < WORD_LEN; i++)
                word_out_o[8*(WORD_LEN-1-i) +: 8] = slot_q[i];
    end

    assign word_valid_o = word_valid_q;
    assign char_count_o = count_q;
    assign echo_char_o  = echo_char_q;
    assign echo_stb_o   = echo_stb_q;
    assign rx_err_o     = rx_err_q;

endmodule

// File: tb/tb_t10_word_buffer.sv
// Bench for t10_word_buffer: directed scenarios plus random byte traffic against a queue-based word model.
module tb_t10_word_buffer;
    localparam int W  = 5;
    localparam int CW = $clog2(W + 1);

    logic            clk = 1'b0;
    logic            nRst;
    logic [7:0]      rx_byte;
    logic            rx_ready, game_rdy, word_ack;
    logic [8*W-1:0]  word_out, nf_word_out;
    logic            word_valid, nf_word_valid;
    logic [CW-1:0]   char_count, nf_char_count;
    logic [7:0]      echo_char, nf_echo_char;
    logic            echo_stb, nf_echo_stb;
    logic            rx_err, nf_rx_err;

    t10_word_buffer #(.WORD_LEN(W), .CASE_FOLD(1'b1)) u_dut (
        .clk(clk), .nRst(nRst), .rx_byte_i(rx_byte), .rx_ready_i(rx_ready),
        .game_rdy_i(game_rdy), .word_ack_i(word_ack), .word_out_o(word_out),
        .word_valid_o(word_valid), .char_count_o(char_count), .echo_char_o(echo_char),
        .echo_stb_o(echo_stb), .rx_err_o(rx_err));

    t10_word_buffer #(.WORD_LEN(W), .CASE_FOLD(1'b0)) u_dut_nf (
        .clk(clk), .nRst(nRst), .rx_byte_i(rx_byte), .rx_ready_i(rx_ready),
        .game_rdy_i(game_rdy), .word_ack_i(word_ack), .word_out_o(nf_word_out),
        .word_valid_o(nf_word_valid), .char_count_o(nf_char_count), .echo_char_o(nf_echo_char),
        .echo_stb_o(nf_echo_stb), .rx_err_o(nf_rx_err));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: 0 idle, 1 collecting, 2 committed; the word is just a queue of letters.
    int          m_state;
    logic [7:0]  m_word[$];
    logic [7:0]  m_echo;
    bit          m_stb, m_err;

    function automatic logic [63:0] m_out();
        logic [63:0] r;
        r = '0;
        if (m_state == 2)
            for (int i = 0; i < m_word.size(); i++) r[8*(W-1-i) +: 8] = m_word[i];
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_word.delete(); m_echo = 8'h00; m_stb = 0; m_err = 0;
    endtask

    task automatic model_step(input bit r, input logic [7:0] b, input bit g, input bit a);
        bit low, up;
        m_stb = 0; m_err = 0;
        low = (b >= "a") && (b <= "z");
        up  = (b >= "A") && (b <= "Z");
        if (!g) begin
            m_state = 0; m_word.delete();
        end else if (m_state == 0) begin
            m_state = 1; m_word.delete();
        end else if (m_state == 1) begin
            if (r) begin
                if (low || up) begin
                    if (m_word.size() < W) begin
                        m_word.push_back(b | 8'h20); m_echo = b | 8'h20; m_stb = 1;
                    end else m_err = 1;
                end else if (b == 8'h08 || b == 8'h7F) begin
                    if (m_word.size() > 0) void'(m_word.pop_back());
                    else m_err = 1;
                end else if (b == 8'h0D && m_word.size() == W) m_state = 2;
                else m_err = 1;
            end
        end else begin
            m_err = r;
            if (a) begin m_state = 1; m_word.delete(); end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 64'(char_count), 64'(m_word.size()));
        chk({tag, ".valid"}, 64'(word_valid), 64'(m_state == 2));
        chk({tag, ".word"},  64'(word_out),   m_out());
        chk({tag, ".echo"},  64'(echo_char),  64'(m_echo));
        chk({tag, ".stb"},   64'(echo_stb),   64'(m_stb));
        chk({tag, ".err"},   64'(rx_err),     64'(m_err));
    endtask

    task automatic step(input string tag, input bit r, input logic [7:0] b, input bit g, input bit a);
        rx_ready = r; rx_byte = b; game_rdy = g; word_ack = a;
        model_step(r, b, g, a);
        @(posedge clk); #1;
        rx_ready = 1'b0; word_ack = 1'b0;
        check_all(tag);
    endtask

    task automatic send_str(input string tag, input string s);
        for (int i = 0; i < s.len(); i++) step(tag, 1'b1, 8'(s[i]), 1'b1, 1'b0);
    endtask

    initial begin
        nRst = 1'b0; rx_ready = 1'b0; rx_byte = 8'h00; game_rdy = 1'b0; word_ack = 1'b0;
        model_reset();
        #22;
        check_all("reset");
        @(negedge clk); nRst = 1'b1;
        step("start", 1'b0, 8'h00, 1'b1, 1'b0);
        step("idle_rx", 1'b1, "q", 1'b1, 1'b0);

        // Asynchronous reset mid-word.
        send_str("pre_rst", "ab");
        game_rdy = 1'b0;
        #2 nRst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk); nRst = 1'b1;
        step("post_rst", 1'b0, 8'h00, 1'b1, 1'b0);

        send_str("crane", "CRANE");
        step("crane_ent", 1'b1, 8'h0D, 1'b1, 1'b0);
        chk("crane_word", 64'(word_out), 64'h6372616E65);
        step("crane_ack", 1'b0, 8'h00, 1'b1, 1'b1);
        chk("crane_cleared", 64'(word_valid), 64'd0);

        send_str("cat", "car");
        step("bs", 1'b1, 8'h08, 1'b1, 1'b0);
        send_str("cat", "ts");
        step("short_ent", 1'b1, 8'h0D, 1'b1, 1'b0);
        chk("short_ent_err", 64'(rx_err), 64'd1);
        send_str("bang", "!");
        send_str("cat", "s");
        step("catss_ent", 1'b1, 8'h0D, 1'b1, 1'b0);
        chk("catss_word", 64'(word_out), 64'h6361747373);
        step("catss_ack", 1'b0, 8'h00, 1'b1, 1'b1);

        step("bs_empty", 1'b1, 8'h7F, 1'b1, 1'b0);
        chk("bs_empty_err", 64'(rx_err), 64'd1);
        send_str("full", "abcdef");
        chk("sixth_err", 64'(rx_err), 64'd1);
        step("full_ent", 1'b1, 8'h0D, 1'b1, 1'b0);
        chk("full_word", 64'(word_out), 64'h6162636465);
        step("full_ack", 1'b0, 8'h00, 1'b1, 1'b1);

        send_str("hello", "hello");
        step("hello_ent", 1'b1, 8'h0D, 1'b1, 1'b0);
        step("commit_rx", 1'b1, "x", 1'b1, 1'b0);
        chk("commit_hold", 64'(word_out), 64'h68656C6C6F);
        step("rx_ack", 1'b1, "y", 1'b1, 1'b1);
        chk("rx_ack_err", 64'(rx_err), 64'd1);
        chk("rx_ack_valid", 64'(word_valid), 64'd0);

        send_str("drop", "abc");
        step("drop", 1'b0, 8'h00, 1'b0, 1'b0);
        step("drop_rx", 1'b1, "a", 1'b0, 1'b0);
        chk("drop_no_err", 64'(rx_err), 64'd0);
        step("resume", 1'b0, 8'h00, 1'b1, 1'b0);
        step("upper", 1'b1, "A", 1'b1, 1'b0);
        chk("nf_upper_err", 64'(nf_rx_err), 64'd1);
        chk("nf_upper_cnt", 64'(nf_char_count), 64'd0);
        step("lower", 1'b1, "b", 1'b1, 1'b0);
        chk("nf_lower_stb", 64'(nf_echo_stb), 64'd1);
        chk("nf_lower_echo", 64'(nf_echo_char), 64'h62);

        for (int n = 0; n < 3000; n++) begin
            int sel;
            logic [7:0] b;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3: b = 8'($urandom_range(8'h61, 8'h7A));
                4:          b = 8'($urandom_range(8'h41, 8'h5A));
                5:          b = 8'h08;
                6:          b = 8'h7F;
                7, 8:       b = 8'h0D;
                default:    b = 8'($urandom_range(0, 255));
            endcase
            step("rand", 1'($urandom_range(0, 1)), b, $urandom_range(0, 49) != 0,
                 $urandom_range(0, 3) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
